// File: rtl/uart_word_loader.sv
// uart_word_loader: bus-side master for the memory-mapped UART register set.
// On start it polls CON, consumes received bytes, assembles a length-prefixed
// little-endian stream (2 length bytes N, then N words of 4 bytes) into 32-bit
// words and writes them to a synchronous memory port at consecutive addresses.
// Ports:
//   reset, clk                 async active-high reset, rising-edge clock
//   start / busy / done        load control and status
//   word_cnt                   words written in the current load
//   mem_we/mem_addr/mem_wdata  memory write port (address wraps silently)
//   uart_CON/uart_CON_read     UART status (bit3 rx done, bit4 tx busy) + clear strobe
//   uart_RXD/uart_RXD_read     received byte in [7:0] + read strobe
//   uart_TXD/uart_TXD_write    echo byte + send strobe
// Optional feature: define UART_LOADER_ECHO_EN to echo every consumed byte back
// through TXD; undefined, TXD and TXD_write are tied to zero.
module uart_word_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           word_cnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           uart_CON,
  output logic                  uart_CON_read,
  input  logic [31:0]           uart_RXD,
  output logic                  uart_RXD_read,
  output logic [31:0]           uart_TXD,
  output logic                  uart_TXD_write
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef UART_LOADER_ECHO_EN
  localparam logic [2:0] S_ECHO  = 3'd5;
`endif

  localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);

  logic [2:0]            r_state;
  logic [1:0]            r_idx;    // byte index within length field / word
  logic [15:0]           r_len;
  logic [31:0]           r_word;
  logic [15:0]           r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
`ifdef UART_LOADER_ECHO_EN
  logic [7:0]            r_byte;   // last consumed byte, sent during ECHO
  logic [2:0]            r_ret;    // state to resume once the echo is sent
`endif

  logic       w_take;
  logic [7:0] w_rx;
  logic [2:0] w_after;
  logic       w_unused_bits;

  // A byte is only consumed while actually waiting for one, so the UART's
  // receive-done flag is never cleared without its data being captured.
  assign w_take = ((r_state == S_LEN) || (r_state == S_DATA)) && uart_CON[3];
  assign w_rx   = uart_RXD[7:0];

  assign w_unused_bits = ^{uart_CON[31:5], uart_CON[4], uart_CON[2:0], uart_RXD[31:8]};

  // Where the FSM goes once the current byte is consumed (ignoring echo).
  always_comb begin
    w_after = r_state;
    if (r_state == S_LEN) begin
      if (!r_idx[0]) begin
        w_after = S_LEN;
      end else if ({w_rx, r_len[7:0]} == 16'd0) begin
        w_after = S_DONE;
      end else begin
        w_after = S_DATA;
      end
    end else if (r_state == S_DATA) begin
      w_after = (r_idx == 2'd3) ? S_WRITE : S_DATA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_len   <= 16'd0;
      r_word  <= 32'd0;
      r_cnt   <= 16'd0;
      r_addr  <= '0;
`ifdef UART_LOADER_ECHO_EN
      r_byte  <= 8'd0;
      r_ret   <= S_IDLE;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_LEN;
            r_idx   <= 2'd0;
            r_cnt   <= 16'd0;
            r_addr  <= LP_BASE;
          end
        end
        S_LEN, S_DATA: begin
          if (w_take) begin
            if (r_state == S_LEN) begin
              if (!r_idx[0]) r_len[7:0]  <= w_rx;
              else           r_len[15:8] <= w_rx;
              r_idx <= r_idx[0] ? 2'd0 : 2'd1;
            end else begin
              r_word[{r_idx, 3'b000} +: 8] <= w_rx;
              r_idx <= r_idx + 2'd1;
            end
`ifdef UART_LOADER_ECHO_EN
            r_byte  <= w_rx;
            r_ret   <= w_after;
            r_state <= S_ECHO;
`else
            r_state <= w_after;
`endif
          end
        end
`ifdef UART_LOADER_ECHO_EN
        S_ECHO: begin
          // Send happens in the cycle the transmitter reports idle.
          if (!uart_CON[4]) r_state <= r_ret;
        end
`endif
        S_WRITE: begin
          r_cnt   <= r_cnt + 16'd1;
          r_addr  <= r_addr + 1'b1;
          r_state <= ((r_cnt + 16'd1) == r_len) ? S_DONE : S_DATA;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done          = (r_state == S_DONE);
  assign word_cnt      = r_cnt;
  assign mem_we        = (r_state == S_WRITE);
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_word;
  assign uart_CON_read = w_take;
  assign uart_RXD_read = w_take;

`ifdef UART_LOADER_ECHO_EN
  assign uart_TXD_write = (r_state == S_ECHO) && !uart_CON[4];
  assign uart_TXD       = (r_state == S_ECHO) ? {24'd0, r_byte} : 32'd0;
`else
  assign uart_TXD_write = 1'b0;
  assign uart_TXD       = 32'd0;
`endif

endmodule

// File: tb/tb_uart_word_loader.sv
module tb_uart_word_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] con = 32'd0;
  logic [31:0] rxd = 32'd0;

  always #5 clk = ~clk;

  logic        busy0, done0, we0, conrd0, rxrd0, txw0;
  logic [15:0] wc0;
  logic [9:0]  addr0;
  logic [31:0] wd0, txd0;

  logic        busy1, done1, we1, conrd1, rxrd1, txw1;
  logic [15:0] wc1;
  logic [1:0]  addr1;
  logic [31:0] wd1, txd1;

  uart_word_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut0 (
    .reset(reset), .clk(clk), .start(start), .busy(busy0), .done(done0),
    .word_cnt(wc0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .uart_CON(con), .uart_CON_read(conrd0), .uart_RXD(rxd), .uart_RXD_read(rxrd0),
    .uart_TXD(txd0), .uart_TXD_write(txw0));

  // Narrow-address copy fed by the same UART stream: exercises address wrap.
  uart_word_loader #(.ADDR_WIDTH(2), .BASE_ADDR(3)) dut1 (
    .reset(reset), .clk(clk), .start(start), .busy(busy1), .done(done1),
    .word_cnt(wc1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .uart_CON(con), .uart_CON_read(conrd1), .uart_RXD(rxd), .uart_RXD_read(rxrd1),
    .uart_TXD(txd1), .uart_TXD_write(txw1));

  int checks = 0;
  int errors = 0;

  int          exp_a0[$];
  int          exp_a1[$];
  logic [31:0] exp_d0[$];
  logic [31:0] exp_d1[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] stim[$];
  logic        last_we;
  logic        last_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: word k of a load lands at (BASE + k) mod 2^ADDR_WIDTH.
  task automatic model_push(input int k, input logic [31:0] w);
    exp_a0.push_back((0 + k) % 1024);
    exp_a1.push_back((3 + k) % 4);
    exp_d0.push_back(w);
    exp_d1.push_back(w);
  endtask

  // Per-cycle compare against the model queues.
  initial begin
    int          a;
    logic [31:0] d;
    logic [7:0]  b;
    forever begin
      @(negedge clk);
      #4;
      chk("rd_pair", rxrd0, conrd0);
      chk("rd_same_dut1", conrd1, conrd0);
      if (conrd0 && !con[3]) chk("rd_without_rx", conrd0, 0);
      if (we0) begin
        if (exp_a0.size() == 0) chk("we0_unexpected", we0, 0);
        else begin
          a = exp_a0.pop_front(); d = exp_d0.pop_front();
          chk("addr0", addr0, a);
          chk("wdata0", wd0, d);
        end
      end
      if (we1) begin
        if (exp_a1.size() == 0) chk("we1_unexpected", we1, 0);
        else begin
          a = exp_a1.pop_front(); d = exp_d1.pop_front();
          chk("addr1", addr1, a);
          chk("wdata1", wd1, d);
        end
      end
`ifdef UART_LOADER_ECHO_EN
      if (txw0) begin
        if (exp_tx.size() == 0) chk("txw_unexpected", txw0, 0);
        else begin
          b = exp_tx.pop_front();
          chk("txd_echo", txd0, {24'd0, b});
        end
      end
`else
      chk("tx_tied_off", {txw0, txd0, txw1, txd1}, 0);
`endif
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    @(negedge clk);
    rxd = {24'hABCDEF, b};
    con[3] = 1'b1;
    while (!got && n < 400) begin
      #1;
      got = conrd0;
      @(posedge clk);
      n++;
      if (!got) @(negedge clk);
    end
`ifdef UART_LOADER_ECHO_EN
    if (got) exp_tx.push_back(b);
`endif
    @(negedge clk);
    con[3] = 1'b0;
    #1;
    last_we = we0;
    last_done = done0;
    if (!got) chk("rx_timeout", got, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    chk("busy_before_start", busy0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy0, 1);
    chk("done_cleared", done0, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done", done0, 1);
    chk("busy_in_done", busy0, 0);
  endtask

  task automatic do_load(input int n, input int nw, input bit use_model, input bit stray);
    logic [31:0] w;
    pulse_start();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    if (stray) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    for (int k = 0; k < nw; k++) begin
      w = stim[k];
      if (use_model) model_push(k, w);
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8]);
`ifndef UART_LOADER_ECHO_EN
        if (j == 3) chk("we_one_cycle_after_byte3", last_we, 1);
`endif
      end
    end
    wait_done();
    chk("word_cnt0", wc0, nw);
    chk("word_cnt1", wc1, nw);
    chk("writes_all_seen", exp_a0.size() + exp_a1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    // Reset held with receive-done pending: nothing may be consumed.
    reset = 1'b1;
    con[3] = 1'b1;
    rxd = 32'h55;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_word_cnt", wc0, 0);
    chk("rst_mem_we", we0, 0);
    chk("rst_mem_addr", addr0, 0);
    chk("rst_mem_wdata", wd0, 0);
    chk("rst_con_read", conrd0, 0);
    chk("rst_rxd_read", rxrd0, 0);
    chk("rst_txd", txd0, 0);
    chk("rst_txd_write", txw0, 0);
    chk("rst_addr1", addr1, 0);
    chk("rst_busy1", busy1, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ignores_rx", conrd0, 0);
    con[3] = 1'b0;

    // Two-word load with literal expectations; a stray start mid-load is ignored.
    exp_a0.push_back(0); exp_d0.push_back(32'h12345678);
    exp_a0.push_back(1); exp_d0.push_back(32'hDEADBEEF);
    exp_a1.push_back(3); exp_d1.push_back(32'h12345678);
    exp_a1.push_back(0); exp_d1.push_back(32'hDEADBEEF);
    stim = '{32'h12345678, 32'hDEADBEEF};
    do_load(2, 2, 1'b0, 1'b1);
    chk("done1_after_load", done1, 1);

    // Zero-length load: no writes, done right after the second length byte.
    stim = '{};
    do_load(0, 0, 1'b0, 1'b0);
`ifndef UART_LOADER_ECHO_EN
    chk("done_after_len_bytes", last_done, 1);
`endif

    // Three words, model-generated expectations (dut1 addresses 3,0,1).
    stim = '{32'hA5A55A5A, 32'h01020304, 32'hFFFFFFFF};
    do_load(3, 3, 1'b1, 1'b0);

    // Reset after 2 of 4 data bytes: the load is abandoned with no write.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h0D);
    send_byte(8'hF0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_word_cnt", wc0, 0);
    chk("abort_mem_we", we0, 0);
    reset = 1'b0;
    stim = '{32'hCAFEF00D};
    do_load(1, 1, 1'b1, 1'b0);

`ifdef UART_LOADER_ECHO_EN
    // Transmitter busy for ~50 cycles after a byte: echo waits, then goes out.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    model_push(0, 32'h44332211);
    con[4] = 1'b1;
    send_byte(8'h11);
    seen = 0;
    repeat (48) begin
      @(negedge clk);
      seen += int'(txw0);
    end
    chk("echo_held_while_tx_busy", seen, 0);
    con[4] = 1'b0;
    #1;
    chk("echo_after_tx_idle", txw0, 1);
    chk("echo_byte", txd0, 32'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    wait_done();
    chk("echo_word_cnt", wc0, 1);
    chk("echo_writes_seen", exp_a0.size(), 0);
`else
    seen = 0;
    chk("no_echo_pending", seen + exp_tx.size(), 0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
